// File: rtl/mpadd64_seq_if.sv
// Operand/result bundle for the 64-bit sequential adder.
// The master side issues start with operands; the slave side returns
// busy/done status together with the sum, carry out and overflow flag.
interface mpadd64_seq_if;
  logic        start;
  logic [63:0] a;
  logic [63:0] b;
  logic        ci;
  logic        busy;
  logic        done;
  logic [63:0] s;
  logic        co;
  logic        ovf;

  modport master (
    output start, a, b, ci,
    input  busy, done, s, co, ovf
  );

  modport slave (
    input  start, a, b, ci,
    output busy, done, s, co, ovf
  );
endinterface

// File: rtl/mpadd64_seq.sv
// 64-bit sequential adder: one 16-bit carry-lookahead adder is reused over
// four slices, least significant first. Carry ripples between slices via a
// carry register, so a result is produced five cycles after acceptance.

// 16-bit carry-lookahead adder built from four 4-bit lookahead groups.
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co
);
  logic [15:0] p;
  logic [15:0] g;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;
  logic [15:0] c;

  // Group generate/propagate, group carries, then in-group carries from the group carry-in.
  always_comb begin
    p  = a ^ b;
    g  = a & b;
    gg = 4'b0000;
    gp = 4'b0000;
    c  = 16'h0000;
    for (int j = 0; j < 4; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j];
    end
    gc[0] = ci;
    gc[1] = gg[0] | (gp[0] & ci);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & ci);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & ci);
    for (int j = 0; j < 4; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
    s  = p ^ c;
    co = gc[4];
  end
endmodule

module mpadd64_seq (
  input  logic             clk,
  input  logic             rst,
  mpadd64_seq_if.slave     bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  idx;
  logic        carry;
  logic [63:0] a_r;
  logic [63:0] b_r;
  logic [15:0] slice_a;
  logic [15:0] slice_b;
  logic [15:0] slice_sum;
  logic        slice_co;

  // Route the operand slice selected by the slice index into the shared adder.
  always_comb begin
    slice_a = 16'h0000;
    slice_b = 16'h0000;
    case (idx)
      2'd0: begin slice_a = a_r[15:0];  slice_b = b_r[15:0];  end
      2'd1: begin slice_a = a_r[31:16]; slice_b = b_r[31:16]; end
      2'd2: begin slice_a = a_r[47:32]; slice_b = b_r[47:32]; end
      2'd3: begin slice_a = a_r[63:48]; slice_b = b_r[63:48]; end
      default: begin slice_a = 16'h0000; slice_b = 16'h0000; end
    endcase
  end

  cla16 u_cla16 (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry),
    .s  (slice_sum),
    .co (slice_co)
  );

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 2'd0;
      carry    <= 1'b0;
      a_r      <= 64'h0;
      b_r      <= 64'h0;
      bus.s    <= 64'h0;
      bus.co   <= 1'b0;
      bus.ovf  <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_r      <= bus.a;
            b_r      <= bus.b;
            carry    <= bus.ci;
            bus.s    <= 64'h0;
            idx      <= 2'd0;
            bus.busy <= 1'b1;
            state    <= ADD;
          end
        end
        ADD: begin
          case (idx)
            2'd0:    bus.s[15:0]  <= slice_sum;
            2'd1:    bus.s[31:16] <= slice_sum;
            2'd2:    bus.s[47:32] <= slice_sum;
            2'd3:    bus.s[63:48] <= slice_sum;
            default: bus.s[15:0]  <= slice_sum;
          endcase
          carry <= slice_co;
          idx   <= idx + 2'd1;
          if (idx == 2'd3) begin
            // Final slice: carry out of bit 63 and signed overflow of the full word.
            bus.co   <= slice_co;
            bus.ovf  <= (a_r[63] == b_r[63]) && (slice_sum[15] != a_r[63]);
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          idx      <= 2'd0;
          state    <= IDLE;
        end
        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          idx      <= 2'd0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mpadd64_seq.sv
// Scoreboard bench for mpadd64_seq: the driver pushes hand-computed results
// into a queue at acceptance and a monitor pops/compares on every done pulse.
module tb_mpadd64_seq;
  typedef struct packed {
    logic [63:0] s;
    logic        co;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cyc;
  int   done_count;
  exp_t exp_q[$];
  exp_t mon_e;

  mpadd64_seq_if bus ();

  mpadd64_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      done_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done_pulse required=none s=%h", bus.s);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sum", bus.s, mon_e.s);
        chk("carry_out", {63'h0, bus.co}, {63'h0, mon_e.co});
        chk("overflow", {63'h0, bus.ovf}, {63'h0, mon_e.ovf});
      end
    end
  end

  task automatic wait_done(output int t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        t  = cyc;
      end
    end
  endtask

  task automatic do_op(input logic [63:0] av, input logic [63:0] bv, input logic civ,
                       input logic [63:0] es, input logic eco, input logic eovf);
    exp_t e;
    @(negedge clk);
    chk("idle_before_start", {63'h0, bus.busy}, 64'h0);
    bus.a = av; bus.b = bv; bus.ci = civ; bus.start = 1'b1;
    @(posedge clk);
    e.s = es; e.co = eco; e.ovf = eovf;
    exp_q.push_back(e);
    #1;
    bus.start = 1'b0;
    bus.a = ~av; bus.b = ~bv; bus.ci = ~civ;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_early_done", {63'h0, bus.done}, 64'h0);
      chk("busy_in_op", {63'h0, bus.busy}, 64'h1);
    end
    @(negedge clk);
    chk("done_latency", {63'h0, bus.done}, 64'h1);
    @(negedge clk);
    chk("done_width", {63'h0, bus.done}, 64'h0);
    chk("busy_cleared", {63'h0, bus.busy}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   dc;
    int   t;
    int   prev;
    bit   ok;
    exp_t e;
    checks = 0; failures = 0; cyc = 0; done_count = 0; prev = 0;
    bus.start = 1'b0; bus.a = 64'h0; bus.b = 64'h0; bus.ci = 1'b0;
    rst = 1'b1;
    #2;
    chk("rst_busy", {63'h0, bus.busy}, 64'h0);
    chk("rst_done", {63'h0, bus.done}, 64'h0);
    chk("rst_s", bus.s, 64'h0);
    chk("rst_co", {63'h0, bus.co}, 64'h0);
    chk("rst_ovf", {63'h0, bus.ovf}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0);
    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    do_op(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 64'h0001_0000_0001_0000, 1'b0, 1'b0);
    do_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    do_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 64'h0, 1'b1, 1'b0);
    do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1);

    // Abort mid-operation (slice index 2) with an asynchronous reset.
    @(negedge clk);
    bus.a = 64'h1111_2222_3333_4444; bus.b = 64'h1; bus.ci = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    dc  = done_count;
    rst = 1'b1;
    #1;
    chk("abort_busy", {63'h0, bus.busy}, 64'h0);
    chk("abort_s", bus.s, 64'h0);
    chk("abort_co", {63'h0, bus.co}, 64'h0);
    chk("abort_ovf", {63'h0, bus.ovf}, 64'h0);
    chk("abort_done", {63'h0, bus.done}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_done", done_count - dc, 0);
    do_op(64'h5, 64'h5, 1'b0, 64'hA, 1'b0, 1'b0);

    // Operand changes and a start pulse during ADD must not disturb the result.
    @(negedge clk);
    dc = done_count;
    bus.a = 64'h1234; bus.b = 64'h1; bus.ci = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    e.s = 64'h1235; e.co = 1'b0; e.ovf = 1'b0;
    exp_q.push_back(e);
    #1 bus.start = 1'b0;
    @(negedge clk);
    bus.a = 64'hFFFF_FFFF_FFFF_FFFF; bus.b = 64'h5555_5555_5555_5555; bus.ci = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("single_done", done_count - dc, 1);

    // Start held high: back-to-back operations every six cycles.
    @(negedge clk);
    bus.a = 64'h0123_4567_89AB_CDEF; bus.b = 64'h1111_1111_1111_1111; bus.ci = 1'b1; bus.start = 1'b1;
    e.s = 64'h1234_5678_9ABC_DF01; e.co = 1'b0; e.ovf = 1'b0;
    for (int n = 0; n < 3; n++) exp_q.push_back(e);
    for (int n = 0; n < 3; n++) begin
      wait_done(t, ok);
      chk("hold_done_seen", {63'h0, ok}, 64'h1);
      if (n > 0) chk("hold_period", t - prev, 6);
      prev = t;
    end
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("final_idle", {63'h0, bus.busy}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
